alu_muldiv_control: RTL

Parametrised next-generation ALU control for the MIPS execute stage. It decodes `alu_op_i`/`alu_function_i` into the 4-bit ALU operation code for single-cycle operations. It also owns the HI/LO register pair and runs an iterative multi-cycle unit for MULT/MULTU/DIV/DIVU. It exports busy/stall handshakes to the hazard logic and a HI/LO read path for MFHI/MFLO.

---
 rtl/alu_muldiv_control_if.sv | 30 +++
 rtl/alu_muldiv_control.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_control_if.sv
// Execute-stage ALU control bundle: decode inputs, operands and HI/LO/mul-div status.
// The master side drives the instruction, the slave side (control block) returns codes and status.
interface alu_muldiv_control_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 3
);
  logic                    valid_i;
  logic [ALU_OP_WIDTH-1:0] alu_op_i;
  logic [5:0]              alu_function_i;
  logic [DATA_WIDTH-1:0]   rs_data_i;
  logic [DATA_WIDTH-1:0]   rt_data_i;
  logic [3:0]              alu_operation_o;
  logic                    hilo_sel_o;
  logic [DATA_WIDTH-1:0]   hilo_data_o;
  logic [DATA_WIDTH-1:0]   hi_o;
  logic [DATA_WIDTH-1:0]   lo_o;
  logic                    busy_o;
  logic                    stall_o;
  logic                    done_o;

  modport master (
    output valid_i, alu_op_i, alu_function_i, rs_data_i, rt_data_i,
    input  alu_operation_o, hilo_sel_o, hilo_data_o, hi_o, lo_o, busy_o, stall_o, done_o
  );

  modport slave (
    input  valid_i, alu_op_i, alu_function_i, rs_data_i, rt_data_i,
    output alu_operation_o, hilo_sel_o, hilo_data_o, hi_o, lo_o, busy_o, stall_o, done_o
  );
endinterface

// File: rtl/alu_muldiv_control.sv
// ALU op decode plus HI/LO owner with iterative MULT/MULTU/DIV/DIVU unit.
// Latency: decode combinational; mul/div W+1 cycles busy, done pulse in cycle W+2.
// Backpressure: HI/LO-class instructions stall while busy; single-cycle ops never stall.
module alu_muldiv_control #(
  parameter int DATA_WIDTH   = 32,
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  alu_muldiv_control_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADDI  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ORI   = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LUI   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_RTYPE = ALU_OP_WIDTH'(7);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     opnd_q;
  logic [W-1:0]     rs_raw_q;
  logic [W-1:0]     hi_q, lo_q;
  logic             busy_q, done_q;
  logic             is_div_q, neg_q, rem_neg_q, div_zero_q;

  logic [5:0] funct;
  logic       is_rtype, hilo_fn, stall, accept;
  logic       start_mul, start_div, is_signed, a_neg, b_neg;
  logic [W-1:0] mag_a, mag_b;
  logic [3:0]   op_code;

  assign funct    = bus.alu_function_i;
  assign is_rtype = (bus.alu_op_i == OP_RTYPE);

  always_comb begin
    hilo_fn = 1'b0;
    case (funct)
      F_MULT, F_MULTU, F_DIV, F_DIVU,
      F_MFHI, F_MFLO, F_MTHI, F_MTLO: hilo_fn = 1'b1;
      default:                        hilo_fn = 1'b0;
    endcase
  end

  always_comb begin
    op_code = 4'b1001;
    case (bus.alu_op_i)
      OP_ADD:  op_code = 4'b0011;
      OP_SUB:  op_code = 4'b0100;
      OP_AND:  op_code = 4'b0000;
      OP_SLT:  op_code = 4'b1000;
      OP_ADDI: op_code = 4'b0011;
      OP_ORI:  op_code = 4'b0010;
      OP_LUI:  op_code = 4'b0101;
      OP_RTYPE: begin
        case (funct)
          F_ADD:   op_code = 4'b0011;
          F_SUB:   op_code = 4'b0100;
          F_AND:   op_code = 4'b0000;
          F_OR:    op_code = 4'b0010;
          F_NOR:   op_code = 4'b0001;
          F_SLL:   op_code = 4'b0110;
          F_SRL:   op_code = 4'b0111;
          F_SLT:   op_code = 4'b1000;
          default: op_code = 4'b1001;
        endcase
      end
      default: op_code = 4'b1001;
    endcase
  end

  assign stall     = bus.valid_i & is_rtype & hilo_fn & (busy_q | (state_q != ST_IDLE));
  assign accept    = bus.valid_i & is_rtype & ~stall;
  assign start_mul = accept & ((funct == F_MULT) | (funct == F_MULTU));
  assign start_div = accept & ((funct == F_DIV) | (funct == F_DIVU));
  assign is_signed = (funct == F_MULT) | (funct == F_DIV);
  assign a_neg     = is_signed & bus.rs_data_i[W-1];
  assign b_neg     = is_signed & bus.rt_data_i[W-1];
  assign mag_a     = a_neg ? (W'(0) - bus.rs_data_i) : bus.rs_data_i;
  assign mag_b     = b_neg ? (W'(0) - bus.rt_data_i) : bus.rt_data_i;

  // Shift-add step: conditionally add multiplicand into the top half, then shift right with carry.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[W-1:1]};

  // Restoring step: shift {rem,quo} left, try subtracting divisor, quotient bit enters at the bottom.
  logic [W:0]     div_up, div_sub;
  logic           div_ge;
  logic [2*W-1:0] div_next;
  assign div_up   = acc_q[2*W-1:W-1];
  assign div_ge   = (div_up >= {1'b0, opnd_q});
  assign div_sub  = div_up - {1'b0, opnd_q};
  assign div_next = {(div_ge ? div_sub[W-1:0] : div_up[W-1:0]), acc_q[W-2:0], div_ge};

  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_hi, fix_lo;
  always_comb begin
    prod   = neg_q ? ((2*W)'(0) - acc_q) : acc_q;
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        fix_hi = rs_raw_q;
        fix_lo = {W{1'b1}};
      end else begin
        fix_hi = rem_neg_q ? (W'(0) - acc_q[2*W-1:W]) : acc_q[2*W-1:W];
        fix_lo = neg_q     ? (W'(0) - acc_q[W-1:0])   : acc_q[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      rs_raw_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_mul | start_div) begin
            state_q    <= start_mul ? ST_MUL : ST_DIV;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_W'(DATA_WIDTH);
            is_div_q   <= start_div;
            neg_q      <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            div_zero_q <= start_div & (bus.rt_data_i == '0);
            rs_raw_q   <= bus.rs_data_i;
            opnd_q     <= start_mul ? mag_a : mag_b;
            acc_q      <= {{W{1'b0}}, (start_mul ? mag_b : mag_a)};
          end else if (accept && funct == F_MTHI) begin
            hi_q <= bus.rs_data_i;
          end else if (accept && funct == F_MTLO) begin
            lo_q <= bus.rs_data_i;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_q <= (state_q == ST_MUL) ? mul_next : div_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.alu_operation_o = op_code;
  assign bus.hilo_sel_o      = bus.valid_i & is_rtype & ((funct == F_MFHI) | (funct == F_MFLO));
  assign bus.hilo_data_o     = (funct == F_MFHI) ? hi_q : lo_q;
  assign bus.hi_o            = hi_q;
  assign bus.lo_o            = lo_q;
  assign bus.busy_o          = busy_q;
  assign bus.stall_o         = stall;
  assign bus.done_o          = done_q;
endmodule
